// File: rtl/mcpu_soc_audio_i2s_tx.sv
// Stereo serial audio transmitter (I2S or left-justified). Software refills an
// MMIO ring buffer of 32-bit slot words using start/half flags.
module mcpu_soc_audio_i2s_tx #(
  parameter int SAMPLE_BITS   = 16,
  parameter int BUF_ADDR_BITS = 5,
  parameter int DIV_BITS      = 8
) (
  input  logic        clkrst_core_clk,
  input  logic        clkrst_core_rst_n,
  input  logic [9:0]  addr,
  input  logic [31:0] data_in,
  input  logic [31:0] write_mask,
  output logic [31:0] data_out,
  output logic        ext_audio_mclk,
  output logic        ext_audio_bclk,
  output logic        ext_audio_lrclk,
  output logic        ext_audio_data
);
  localparam int                       DEPTH      = 1 << BUF_ADDR_BITS;
  localparam logic [BUF_ADDR_BITS-1:0] HALF_IDX   = BUF_ADDR_BITS'(DEPTH / 2);
  localparam logic [5:0]               SAMPLE_LEN = 6'(SAMPLE_BITS);
  localparam logic [31:0]              CTRL_MASK  = {{(24-DIV_BITS){1'b0}}, {DIV_BITS{1'b1}}, 8'h03};

  logic [31:0]              buf_mem [DEPTH];
  logic [31:0]              ctrl_q, ctrl_new, ctrl_nxt, buf_rd, fetch_word, slot_word;
  logic [2:0]               status, status_set, status_clr;  // {underrun, half, start}
  logic                     enable, mode, enable_nxt, mode_nxt;
  logic [DIV_BITS-1:0]      div, div_nxt, div_act, div_cnt;
  logic [BUF_ADDR_BITS-1:0] rd_ptr, buf_idx;
  logic [5:0]               pos, pos_nxt;
  logic                     slot_mode;
  logic                     wr, status_wr, ctrl_wr, buf_wr;
  logic                     play_start, tick, fall, fetch, fetch_start, fetch_half;

  assign wr        = |write_mask;
  assign status_wr = wr && (addr == 10'd0);
  assign ctrl_wr   = wr && (addr == 10'd1);
  assign buf_wr    = wr && addr[9];
  assign buf_idx   = addr[BUF_ADDR_BITS-1:0];
  assign buf_rd    = buf_mem[buf_idx];

  assign ctrl_new   = (ctrl_q & ~write_mask) | (data_in & write_mask);
  assign ctrl_nxt   = ctrl_wr ? (ctrl_new & CTRL_MASK) : ctrl_q;
  assign enable     = ctrl_q[0];
  assign mode       = ctrl_q[1];
  assign div        = ctrl_q[8 +: DIV_BITS];
  assign enable_nxt = ctrl_nxt[0];
  assign mode_nxt   = ctrl_nxt[1];
  assign div_nxt    = ctrl_nxt[8 +: DIV_BITS];

  assign play_start  = enable_nxt && !enable;
  assign tick        = (div_cnt == div_act);
  assign fall        = enable && enable_nxt && tick && ext_audio_bclk;
  assign pos_nxt     = pos + 6'd1;
  assign fetch       = fall && (pos_nxt[4:0] == 5'd0);
  assign fetch_word  = buf_mem[rd_ptr];
  assign fetch_start = fetch && (rd_ptr == '0);
  assign fetch_half  = fetch && (rd_ptr == HALF_IDX);

  // Bit p of a slot; I2S delays the MSB by one bit clock after the lrclk edge.
  function automatic logic slot_bit(input logic [31:0] word, input logic [4:0] p,
                                    input logic left_just);
    logic [5:0] k;
    k = {1'b0, p} - {5'd0, ~left_just};
    return (k < SAMPLE_LEN) ? word[5'd31 - k[4:0]] : 1'b0;
  endfunction

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    data_out = '0;
    if (addr == 10'd0)      data_out = {29'd0, status};
    else if (addr == 10'd1) data_out = ctrl_q;
    else if (addr[9])       data_out = buf_rd;
  end

  // NOTE: state is updated with non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge clkrst_core_clk or negedge clkrst_core_rst_n) begin
    if (!clkrst_core_rst_n) ctrl_q <= '0;
    else                    ctrl_q <= ctrl_nxt;
  end

  // A hardware set in the same cycle as a software clear leaves the bit set.
  assign status_clr = status_wr ? (data_in[2:0] & write_mask[2:0]) : 3'd0;
  assign status_set = {(fetch_start && status[0]) || (fetch_half && status[1]),
                       fetch_half, fetch_start || play_start};

  always_ff @(posedge clkrst_core_clk or negedge clkrst_core_rst_n) begin
    if (!clkrst_core_rst_n) status <= '0;
    else                    status <= (status & ~status_clr) | status_set;
  end

  // NOTE: the buffer must read back as zero after reset, so it is built from
  // resettable flops rather than an inferred RAM.
  always_ff @(posedge clkrst_core_clk or negedge clkrst_core_rst_n) begin
    if (!clkrst_core_rst_n) begin
      for (int i = 0; i < DEPTH; i++) buf_mem[i] <= '0;
    end else if (buf_wr) begin
      buf_mem[buf_idx] <= (buf_rd & ~write_mask) | (data_in & write_mask);
    end
  end

  always_ff @(posedge clkrst_core_clk or negedge clkrst_core_rst_n) begin
    if (!clkrst_core_rst_n) begin
      slot_word <= '0; rd_ptr <= '0; pos <= '0; div_cnt <= '0; div_act <= '0;
      slot_mode <= 1'b0; ext_audio_mclk <= 1'b0; ext_audio_bclk <= 1'b0;
      ext_audio_lrclk <= 1'b0; ext_audio_data <= 1'b0;
    end else if (!enable_nxt) begin
      slot_word <= '0; rd_ptr <= '0; pos <= '0; div_cnt <= '0; div_act <= '0;
      slot_mode <= 1'b0; ext_audio_mclk <= 1'b0; ext_audio_bclk <= 1'b0;
      ext_audio_lrclk <= 1'b0; ext_audio_data <= 1'b0;
    end else if (play_start) begin
      slot_word       <= buf_mem[0];
      rd_ptr          <= BUF_ADDR_BITS'(1);
      pos             <= '0;
      div_cnt         <= '0;
      div_act         <= div_nxt;
      slot_mode       <= mode_nxt;
      ext_audio_mclk  <= 1'b0;
      ext_audio_bclk  <= 1'b0;
      ext_audio_lrclk <= 1'b0;
      ext_audio_data  <= slot_bit(buf_mem[0], 5'd0, mode_nxt);
    end else begin
      ext_audio_mclk <= ~ext_audio_mclk;
      if (tick) begin
        div_cnt        <= '0;
        div_act        <= div;
        ext_audio_bclk <= ~ext_audio_bclk;
        if (fall) begin
          pos             <= pos_nxt;
          ext_audio_lrclk <= pos_nxt[5];
          if (fetch) begin
            slot_word      <= fetch_word;
            slot_mode      <= mode;
            rd_ptr         <= rd_ptr + BUF_ADDR_BITS'(1);
            ext_audio_data <= slot_bit(fetch_word, 5'd0, mode);
          end else begin
            ext_audio_data <= slot_bit(slot_word, pos_nxt[4:0], slot_mode);
          end
        end
      end else begin
        div_cnt <= div_cnt + DIV_BITS'(1);
      end
    end
  end
endmodule

// File: tb/tb_mcpu_soc_audio_i2s_tx.sv
// Self-checking bench: an arithmetic model of the serial pins (cycle count since
// enable -> bit position -> slot word bit) plus hand-computed register expectations.
module tb_mcpu_soc_audio_i2s_tx;
  localparam int DEPTH = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  addr = '0;
  logic [31:0] data_in = '0;
  logic [31:0] write_mask = '0;
  logic [31:0] data_out;
  logic        mclk, bclk, lrclk, sdata;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mcpu_soc_audio_i2s_tx dut (
    .clkrst_core_clk   (clk),
    .clkrst_core_rst_n (rst_n),
    .addr              (addr),
    .data_in           (data_in),
    .write_mask        (write_mask),
    .data_out          (data_out),
    .ext_audio_mclk    (mclk),
    .ext_audio_bclk    (bclk),
    .ext_audio_lrclk   (lrclk),
    .ext_audio_data    (sdata)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h, expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Bus-observing model: buffer contents, control word, and cycles since enable.
  logic [31:0] m_buf [DEPTH];
  logic [31:0] m_ctl, nc;
  logic        m_run, m_lj, ctl_wr;
  int          m_t, m_div;

  assign ctl_wr = (|write_mask) && (addr == 10'd1);
  assign nc     = (m_ctl & ~write_mask) | (data_in & write_mask);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run <= 1'b0; m_t <= 0; m_ctl <= '0; m_div <= 0; m_lj <= 1'b0;
      for (int i = 0; i < DEPTH; i++) m_buf[i] <= '0;
    end else begin
      if ((|write_mask) && addr[9])
        m_buf[addr[4:0]] <= (m_buf[addr[4:0]] & ~write_mask) | (data_in & write_mask);
      if (ctl_wr) m_ctl <= nc;
      if (ctl_wr && nc[0] && !m_run) begin
        m_run <= 1'b1; m_t <= 0; m_div <= int'(nc[15:8]); m_lj <= nc[1];
      end else if (ctl_wr && !nc[0]) begin
        m_run <= 1'b0; m_t <= 0;
      end else if (m_run) begin
        m_t <= m_t + 1;
      end
    end
  end

  // {mclk, bclk, lrclk, data} after t cycles of playback.
  function automatic logic [3:0] expect_pins(input int t, input int dv, input logic lj);
    int per, n, p, k;
    logic [31:0] w;
    logic d;
    per = 2 * (dv + 1);
    n   = t / per;
    p   = n % 32;
    k   = lj ? p : p - 1;
    w   = m_buf[(n / 32) % DEPTH];
    d   = (k >= 0 && k < 16) ? w[31 - k] : 1'b0;
    return {(t % 2) == 1, (t % per) > dv, (n % 64) >= 32, d};
  endfunction

  always @(negedge clk) begin
    if (rst_n)
      check("pins {mclk,bclk,lrclk,data}", {28'd0, mclk, bclk, lrclk, sdata},
            m_run ? {28'd0, expect_pins(m_t, m_div, m_lj)} : 32'd0);
  end

  // First-frame captures used by the literal expectations.
  logic [63:0] cap_data = '0;
  logic [15:0] cap_bclk = '0;
  always @(negedge clk) begin
    if (rst_n && m_run) begin
      if (m_t < 16) cap_bclk[m_t[3:0]] <= bclk;
      if ((m_t % (2 * (m_div + 1))) == 0 && (m_t / (2 * (m_div + 1))) < 64)
        cap_data[6'(63 - m_t / (2 * (m_div + 1)))] <= sdata;
    end
  end

  task automatic bus_write(input logic [9:0] a, input logic [31:0] d, input logic [31:0] m);
    addr = a; data_in = d; write_mask = m;
    @(posedge clk);
    #1;
    write_mask = '0; data_in = '0; addr = '0;
    @(negedge clk);
  endtask

  task automatic bus_read(input string name, input logic [9:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    check(name, data_out, exp);
    addr = '0;
    @(negedge clk);
  endtask

  task automatic wait_t(input int target);
    int guard;
    guard = 0;
    while (m_t < target && guard < 10000) begin
      @(negedge clk);
      guard++;
    end
    if (m_t < target) check("wait_t timeout", m_t, target);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset after buffer and control have been written
    bus_write(10'h200, 32'h1111_1111, '1);
    bus_write(10'd1, 32'h0000_0502, '1);
    bus_read("ctrl readback", 10'd1, 32'h0000_0502);
    bus_read("buf0 readback", 10'h200, 32'h1111_1111);
    bus_write(10'd5, 32'hFFFF_FFFF, '1);
    bus_read("unmapped addr", 10'd5, 32'h0);
    rst_n = 1'b0;
    #1;
    check("reset pins", {28'd0, mclk, bclk, lrclk, sdata}, 32'h0);
    bus_read("reset status", 10'd0, 32'h0);
    bus_read("reset ctrl", 10'd1, 32'h0);
    bus_read("reset buf0", 10'h200, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Buffer setup, masked RMW, control unused bits
    bus_write(10'h200, 32'hA5A5_0000, '1);
    bus_write(10'h201, 32'h1234_0000, '1);
    bus_write(10'h202, 32'hFFFF_FFFF, '1);
    bus_write(10'h202, 32'h0000_0000, 32'h0000_FFFF);
    bus_read("masked rmw", 10'h202, 32'hFFFF_0000);
    bus_write(10'h210, 32'hC3C3_0000, '1);
    bus_write(10'd1, 32'hFFFF_FF02, '1);
    bus_read("ctrl unused bits", 10'd1, 32'h0000_FF02);

    // Left-justified, div = 0
    bus_write(10'd1, 32'h0000_0003, '1);
    wait_t(130);
    check("lj left slot", cap_data[63:32], 32'hA5A5_0000);
    check("lj right slot", cap_data[31:0], 32'h1234_0000);
    check("bclk div0", {16'd0, cap_bclk}, 32'h0000_AAAA);
    bus_read("status after enable", 10'd0, 32'h1);
    bus_write(10'd1, 32'h0, '1);
    check("disabled pins", {28'd0, mclk, bclk, lrclk, sdata}, 32'h0);

    // I2S, div = 0
    bus_write(10'd0, 32'h7, '1);
    bus_write(10'd1, 32'h0000_0001, '1);
    wait_t(130);
    check("i2s left slot", cap_data[63:32], 32'h52D2_8000);
    check("i2s right slot", cap_data[31:0], 32'h091A_0000);
    bus_read("i2s status", 10'd0, 32'h1);
    bus_write(10'd1, 32'h0, '1);

    // div = 3: 4-cycle bclk phases, half flag at frame 8
    bus_write(10'd0, 32'h7, '1);
    bus_write(10'd1, 32'h0000_0301, '1);
    wait_t(20);
    check("bclk div3", {16'd0, cap_bclk}, 32'h0000_F0F0);
    wait_t(4000);
    bus_read("status before half", 10'd0, 32'h1);
    wait_t(4100);
    bus_read("status half", 10'd0, 32'h3);
    bus_write(10'd1, 32'h0, '1);

    // Flag handling, wraparound underrun, disable / re-enable
    bus_write(10'd0, 32'h7, '1);
    bus_write(10'd1, 32'h0000_0003, '1);
    wait_t(10);
    bus_write(10'd0, 32'h1, '1);
    bus_read("start w1c", 10'd0, 32'h0);
    wait_t(1023);
    bus_write(10'd0, 32'h2, '1);
    bus_read("set beats w1c", 10'd0, 32'h2);
    wait_t(2060);
    bus_read("start on wrap", 10'd0, 32'h3);
    bus_write(10'd0, 32'h1, '1);
    wait_t(3080);
    bus_read("half underrun", 10'd0, 32'h6);
    wait_t(3101);
    bus_write(10'd1, 32'h0, '1);
    check("disable mid-frame", {28'd0, mclk, bclk, lrclk, sdata}, 32'h0);
    bus_write(10'd1, 32'h0000_0003, '1);
    check("re-enable pins", {28'd0, mclk, bclk, lrclk, sdata}, 32'h1);
    bus_read("re-enable status", 10'd0, 32'h7);

    // Async reset in the middle of a bit
    wait_t(37);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset pins", {28'd0, mclk, bclk, lrclk, sdata}, 32'h0);
    bus_read("async reset status", 10'd0, 32'h0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
